// File: rtl/cpu_bus_sequencer.sv
// Sequences 6502 I/O-window bus cycles in the fast clock domain and arbitrates the
// single CPU data-out path and bus buffer enable between NUM_SLAVES peripherals.
module cpu_bus_sequencer #(
  parameter int          NUM_SLAVES   = 4,
  parameter int          SYNC_STAGES  = 2,
  parameter int          SETUP_CYCLES = 8,
  parameter logic [7:0]  DEFAULT_DATA = 8'hAA
) (
  input  logic                      clk_96mhz,
  input  logic                      reset,
  input  logic                      cpu_clk,
  input  logic                      cpu_rwb,
  input  logic                      cs_mary_n,
  input  logic [15:0]               addr,
  input  logic [7:0]                data_in,
  input  logic [NUM_SLAVES-1:0]     slave_sel,
  input  logic [NUM_SLAVES*8-1:0]   slave_rdata,
  input  logic                      err_clr,
  output logic [NUM_SLAVES-1:0]     rd_strobe,
  output logic [NUM_SLAVES-1:0]     wr_strobe,
  output logic [7:0]                reg_addr,
  output logic [7:0]                reg_wdata,
  output logic [7:0]                data_out,
  output logic                      b_en,
  output logic                      bus_error
);

  localparam int                     FLUSH_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FLUSH_W-1:0]     FLUSH_DONE = FLUSH_W'(SYNC_STAGES);
  localparam logic [4:0]             SETUP_LOAD = 5'(SETUP_CYCLES);
  localparam logic [NUM_SLAVES-1:0]  SEL_ONE    = NUM_SLAVES'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_READ      = 3'd2,
    S_READ_DEF  = 3'd3,
    S_WRITE     = 3'd4,
    S_WAIT_FALL = 3'd5
  } state_t;

  function automatic logic is_onehot(input logic [NUM_SLAVES-1:0] v);
    return (v != '0) && ((v & (v - SEL_ONE)) == '0);
  endfunction

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  clk_sync_q;
  logic [SYNC_STAGES-1:0]  rwb_sync_q;
  logic [SYNC_STAGES-1:0]  cs_sync_q;
  logic                    phi2_hist_q;
  logic [FLUSH_W-1:0]      flush_cnt_q;
  logic                    armed_q;
  logic [4:0]              cnt_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [NUM_SLAVES-1:0]   rd_strobe_q;
  logic [NUM_SLAVES-1:0]   wr_strobe_q;
  logic [7:0]              reg_addr_q;
  logic [7:0]              reg_wdata_q;
  logic [7:0]              data_out_q;
  logic                    b_en_q;
  logic                    bus_error_q;

  logic                    phi2_s;
  logic                    rise_s;
  logic                    fall_s;
  logic                    cs_n_s;
  logic                    rwb_s;
  logic                    sel_ok_s;
  logic [7:0]              rdata_mux_s;
  logic                    unused_s;

  assign phi2_s   = clk_sync_q[SYNC_STAGES-1];
  assign rise_s   = phi2_s & ~phi2_hist_q;
  assign fall_s   = ~phi2_s & phi2_hist_q;
  assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
  assign rwb_s    = rwb_sync_q[SYNC_STAGES-1];
  assign sel_ok_s = is_onehot(slave_sel);
  assign unused_s = ^addr[15:8];

  // Read-data mux driven by the select latched at sample time.
  always_comb begin
    rdata_mux_s = 8'h00;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rdata_mux_s = rdata_mux_s | (slave_rdata[8*i +: 8] & {8{sel_q[i]}});
    end
  end

  // Synchronisers, phi2 edge history, and post-reset arming.
  // A rise is only trusted once the pipeline has flushed and phi2 was seen low,
  // so a phase already in progress at reset release is never sequenced.
  always_ff @(posedge clk_96mhz or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '0;
      rwb_sync_q  <= '0;
      cs_sync_q   <= '0;
      phi2_hist_q <= 1'b0;
      flush_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], cpu_clk};
      rwb_sync_q  <= {rwb_sync_q[SYNC_STAGES-2:0], cpu_rwb};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_mary_n};
      phi2_hist_q <= phi2_s;
      if (flush_cnt_q != FLUSH_DONE) begin
        flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
      end else if (!phi2_s) begin
        armed_q <= 1'b1;
      end else begin
        armed_q <= armed_q;
      end
    end
  end

  // Bus-cycle FSM with registered strobes, data path and sticky error.
  always_ff @(posedge clk_96mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      sel_q       <= '0;
      rd_strobe_q <= '0;
      wr_strobe_q <= '0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      data_out_q  <= 8'h00;
      b_en_q      <= 1'b1;
      bus_error_q <= 1'b0;
    end else begin
      rd_strobe_q <= '0;
      wr_strobe_q <= '0;
      // A set later in this block overrides a same-cycle clear.
      if (err_clr) begin
        bus_error_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          b_en_q <= 1'b1;
          if (rise_s && armed_q) begin
            cnt_q   <= SETUP_LOAD;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (fall_s) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 5'd1) begin
            if (cs_n_s) begin
              state_q <= S_WAIT_FALL;
            end else if (sel_ok_s) begin
              reg_addr_q <= addr[7:0];
              sel_q      <= slave_sel;
              if (rwb_s) begin
                rd_strobe_q <= slave_sel;
                state_q     <= S_READ;
              end else begin
                state_q     <= S_WRITE;
              end
            end else begin
              bus_error_q <= 1'b1;
              state_q     <= rwb_s ? S_READ_DEF : S_WAIT_FALL;
            end
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_READ: begin
          if (fall_s) begin
            b_en_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            data_out_q <= rdata_mux_s;
            b_en_q     <= 1'b0;
          end
        end
        S_READ_DEF: begin
          if (fall_s) begin
            b_en_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            data_out_q <= DEFAULT_DATA;
            b_en_q     <= 1'b0;
          end
        end
        S_WRITE: begin
          if (fall_s) begin
            wr_strobe_q <= sel_q;
            state_q     <= S_IDLE;
          end else begin
            reg_wdata_q <= data_in;
          end
        end
        S_WAIT_FALL: begin
          if (fall_s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          b_en_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_strobe = rd_strobe_q;
  assign wr_strobe = wr_strobe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign data_out  = data_out_q;
  assign b_en      = b_en_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer: expected strobes are queued as each bus
// cycle is driven and matched by a monitor as the DUT emits them.
module tb_cpu_bus_sequencer;

  logic        clk_96mhz = 1'b0;
  logic        reset;
  logic        cpu_clk;
  logic        cpu_rwb;
  logic        cs_mary_n;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [3:0]  slave_sel;
  logic [31:0] slave_rdata;
  logic        err_clr;
  logic [3:0]  rd_strobe;
  logic [3:0]  wr_strobe;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  data_out;
  logic        b_en;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_wr;
    logic [3:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
  } sb_item_t;

  sb_item_t exp_q[$];
  sb_item_t mon_e;
  logic     b_en_low_seen;
  logic     err_seen;

  cpu_bus_sequencer dut (
    .clk_96mhz  (clk_96mhz),
    .reset      (reset),
    .cpu_clk    (cpu_clk),
    .cpu_rwb    (cpu_rwb),
    .cs_mary_n  (cs_mary_n),
    .addr       (addr),
    .data_in    (data_in),
    .slave_sel  (slave_sel),
    .slave_rdata(slave_rdata),
    .err_clr    (err_clr),
    .rd_strobe  (rd_strobe),
    .wr_strobe  (wr_strobe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .data_out   (data_out),
    .b_en       (b_en),
    .bus_error  (bus_error)
  );

  always #5 clk_96mhz = ~clk_96mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_wr, input logic [3:0] sel, input logic [7:0] a, input logic [7:0] wd);
    sb_item_t it;
    it.is_wr = is_wr;
    it.sel   = sel;
    it.addr  = a;
    it.wdata = wd;
    exp_q.push_back(it);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_96mhz);
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk_96mhz) begin
    if (reset === 1'b1 && (rd_strobe !== 4'h0 || wr_strobe !== 4'h0)) begin
      chk("strobe_exclusive", {31'd0, (rd_strobe != 4'h0) && (wr_strobe != 4'h0)}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {24'd0, rd_strobe, wr_strobe}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_strobe", {28'd0, rd_strobe}, mon_e.is_wr ? 32'd0 : {28'd0, mon_e.sel});
        chk("wr_strobe", {28'd0, wr_strobe}, mon_e.is_wr ? {28'd0, mon_e.sel} : 32'd0);
        chk("reg_addr", {24'd0, reg_addr}, {24'd0, mon_e.addr});
        if (mon_e.is_wr) begin
          chk("reg_wdata", {24'd0, reg_wdata}, {24'd0, mon_e.wdata});
        end
      end
    end
  end

  initial begin
    reset       = 1'b0;
    cpu_clk     = 1'b0;
    cpu_rwb     = 1'b1;
    cs_mary_n   = 1'b1;
    addr        = 16'h0000;
    data_in     = 8'h00;
    slave_sel   = 4'h0;
    slave_rdata = 32'h0000_0000;
    err_clr     = 1'b0;
    wait_n(3);
    chk("rst_rd_strobe", {28'd0, rd_strobe}, 32'd0);
    chk("rst_wr_strobe", {28'd0, wr_strobe}, 32'd0);
    chk("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    chk("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_b_en", {31'd0, b_en}, 32'd1);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    reset = 1'b1;
    wait_n(10);

    // Read slave 1
    cs_mary_n   = 1'b0;
    cpu_rwb     = 1'b1;
    addr        = 16'hD012;
    slave_sel   = 4'b0010;
    slave_rdata = 32'h0000_5C00;
    push(1'b0, 4'b0010, 8'h12, 8'h00);
    cpu_clk = 1'b1;
    wait_n(11);
    chk("rd_b_en_before_drive", {31'd0, b_en}, 32'd1);
    wait_n(1);
    chk("rd_b_en_drive", {31'd0, b_en}, 32'd0);
    wait_n(2);
    chk("rd_data_out", {24'd0, data_out}, 32'h5C);
    wait_n(34);
    cpu_clk = 1'b0;
    wait_n(2);
    chk("rd_b_en_hold_after_fall", {31'd0, b_en}, 32'd0);
    wait_n(1);
    chk("rd_b_en_release", {31'd0, b_en}, 32'd1);
    chk("rd_data_hold", {24'd0, data_out}, 32'h5C);
    wait_n(45);

    // Write slave 0 with mid-phase data change
    cpu_rwb   = 1'b0;
    addr      = 16'hD001;
    slave_sel = 4'b0001;
    data_in   = 8'h11;
    push(1'b1, 4'b0001, 8'h01, 8'h3F);
    b_en_low_seen = 1'b0;
    cpu_clk = 1'b1;
    for (int i = 0; i < 96; i++) begin
      if (i == 20) data_in = 8'h3F;
      if (i == 48) cpu_clk = 1'b0;
      @(negedge clk_96mhz);
      if (b_en !== 1'b1) b_en_low_seen = 1'b1;
    end
    chk("wr_b_en_high", {31'd0, b_en_low_seen}, 32'd0);
    chk("wr_reg_wdata", {24'd0, reg_wdata}, 32'h3F);

    // Ten unselected phi2 periods
    cs_mary_n = 1'b1;
    cpu_rwb   = 1'b1;
    slave_sel = 4'b0001;
    b_en_low_seen = 1'b0;
    err_seen      = 1'b0;
    for (int p = 0; p < 10; p++) begin
      cpu_clk = 1'b1;
      for (int i = 0; i < 96; i++) begin
        if (i == 48) cpu_clk = 1'b0;
        @(negedge clk_96mhz);
        if (b_en !== 1'b1) b_en_low_seen = 1'b1;
        if (bus_error !== 1'b0) err_seen = 1'b1;
      end
    end
    chk("unsel_b_en", {31'd0, b_en_low_seen}, 32'd0);
    chk("unsel_bus_error", {31'd0, err_seen}, 32'd0);

    // Invalid select on a read
    cs_mary_n   = 1'b0;
    cpu_rwb     = 1'b1;
    slave_sel   = 4'b0110;
    slave_rdata = 32'h1234_5678;
    cpu_clk = 1'b1;
    wait_n(14);
    chk("inv_data_out", {24'd0, data_out}, 32'hAA);
    chk("inv_b_en", {31'd0, b_en}, 32'd0);
    chk("inv_bus_error", {31'd0, bus_error}, 32'd1);
    wait_n(34);
    cpu_clk = 1'b0;
    wait_n(48);
    chk("inv_error_sticky", {31'd0, bus_error}, 32'd1);
    err_clr = 1'b1;
    wait_n(1);
    err_clr = 1'b0;
    chk("err_clr_alone", {31'd0, bus_error}, 32'd0);

    // Invalid write with err_clr on the same edge as the set
    cpu_rwb   = 1'b0;
    slave_sel = 4'b0000;
    cpu_clk = 1'b1;
    wait_n(10);
    err_clr = 1'b1;
    wait_n(1);
    err_clr = 1'b0;
    chk("set_beats_clear", {31'd0, bus_error}, 32'd1);
    chk("inv_wr_b_en", {31'd0, b_en}, 32'd1);
    wait_n(37);
    cpu_clk = 1'b0;
    wait_n(48);
    err_clr = 1'b1;
    wait_n(1);
    err_clr = 1'b0;
    chk("err_clr_again", {31'd0, bus_error}, 32'd0);

    // Runt phi2
    cpu_rwb   = 1'b1;
    slave_sel = 4'b0010;
    cpu_clk = 1'b1;
    wait_n(4);
    cpu_clk = 1'b0;
    wait_n(48);
    chk("runt_b_en", {31'd0, b_en}, 32'd1);
    chk("runt_bus_error", {31'd0, bus_error}, 32'd0);

    // Reset in the middle of a read
    addr        = 16'hD0F7;
    slave_sel   = 4'b0100;
    slave_rdata = 32'h00C3_0000;
    push(1'b0, 4'b0100, 8'hF7, 8'h00);
    cpu_clk = 1'b1;
    wait_n(20);
    chk("pre_rst_b_en", {31'd0, b_en}, 32'd0);
    chk("pre_rst_data", {24'd0, data_out}, 32'hC3);
    reset = 1'b0;
    #1;
    chk("mid_rst_b_en", {31'd0, b_en}, 32'd1);
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    chk("mid_rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    wait_n(1);
    reset = 1'b1;
    wait_n(27);
    chk("partial_b_en", {31'd0, b_en}, 32'd1);
    cpu_clk = 1'b0;
    wait_n(48);

    // Full read after reset recovery
    addr = 16'hD0A5;
    push(1'b0, 4'b0100, 8'hA5, 8'h00);
    cpu_clk = 1'b1;
    wait_n(14);
    chk("post_rst_data", {24'd0, data_out}, 32'hC3);
    chk("post_rst_b_en", {31'd0, b_en}, 32'd0);
    wait_n(34);
    cpu_clk = 1'b0;
    wait_n(48);
    chk("post_rst_b_en_release", {31'd0, b_en}, 32'd1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_sequencer.md
Name: cpu_bus_sequencer

Overview:
- Sequences every 6502 bus cycle that targets the FPGA-mapped I/O window (cs_mary_n low) in the clk_96mhz domain, and shares the single CPU data-out path between NUM_SLAVES peripherals (comms, VIC interrupts, later blocks).
- Synchronises phi2, waits for the address to settle, then issues one-cycle read/write strobes to exactly one slave.
- Owns data_out and the buffer enable b_en, replacing the ad-hoc priority mux and b_en logic in top.

Parameters:
- NUM_SLAVES, 4: number of peripheral ports; sets slave_sel, strobe and rdata widths.
- SYNC_STAGES, 2: flops on the cpu_clk, cpu_rwb and cs_mary_n synchronisers (minimum 2).
- SETUP_CYCLES, 8: clk_96mhz cycles after the synchronised phi2 rise before the address is sampled (1..31).
- DEFAULT_DATA, 8'hAA: value driven on reads with an invalid select.

Ports:
- clk_96mhz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_clk  in  1  raw phi2 from the CPU (asynchronous).
- cpu_rwb  in  1  raw CPU read/write (1 = read).
- cs_mary_n  in  1  I/O window select from the memory map, active-low.
- addr  in  16  cleaned CPU address.
- data_in  in  8  cleaned CPU write data.
- slave_sel  in  NUM_SLAVES  slave select from the decoder; must be one-hot.
- slave_rdata  in  NUM_SLAVES*8  read data; slave i occupies bits [8i+7:8i].
- err_clr  in  1  clears bus_error.
- rd_strobe  out  NUM_SLAVES  one-cycle read pulse (for side-effect reads).
- wr_strobe  out  NUM_SLAVES  one-cycle write pulse.
- reg_addr  out  8  latched addr[7:0].
- reg_wdata  out  8  latched write data.
- data_out  out  8  data toward the CPU bus buffer.
- b_en  out  1  bus buffer enable, active-low (0 = drive the CPU bus).
- bus_error  out  1  sticky error flag for an invalid select.

Behaviour:
- Reset values (asserted asynchronously): rd_strobe = 0, wr_strobe = 0, reg_addr = 0, reg_wdata = 0, data_out = 0, b_en = 1, bus_error = 0, state = IDLE, synchronisers = 0.
- Input synchronisation: cpu_clk, cpu_rwb and cs_mary_n each pass through SYNC_STAGES flops. One extra history flop gives phi2 rise/fall detect pulses. Latency from a pin edge to the detect pulse is SYNC_STAGES+1 cycles.
- State IDLE: b_en = 1. On a rise pulse, load cnt = SETUP_CYCLES and go to SETTLE.
- State SETTLE: cnt decrements each cycle.
  - Fall pulse here is a runt cycle: go to IDLE with no strobe and no error.
  - At cnt == 1, sample the synced cs_mary_n, synced rwb, slave_sel and addr[7:0], then act as follows.
  - cs_mary_n = 1: go to WAIT_FALL. No strobes, b_en stays 1.
  - Selected, slave_sel one-hot, read: reg_addr <= addr[7:0]; rd_strobe[i] = 1 for exactly one cycle; go to READ.
  - Selected, slave_sel one-hot, write: reg_addr <= addr[7:0]; go to WRITE.
  - Selected, slave_sel zero or multi-hot: bus_error <= 1; no strobes. A read goes to READ_DEF; a write goes to WAIT_FALL.
- State READ: the cycle after rd_strobe, data_out <= slave i rdata and b_en <= 0. data_out is re-registered every cycle so slaves may update combinationally after rd_strobe.
- State READ_DEF: data_out <= DEFAULT_DATA and b_en <= 0.
- READ or READ_DEF on a fall pulse: b_en <= 1 on that registered edge, data_out holds its last value, go to IDLE.
- State WRITE: reg_wdata <= data_in every cycle while in WRITE. On a fall pulse, freeze reg_wdata (it holds the value captured the cycle before the fall is detected), assert wr_strobe[i] for exactly one cycle, go to IDLE.
- State WAIT_FALL: go to IDLE on a fall pulse.
- A rise pulse outside IDLE is ignored. No strobe is ever emitted twice per phi2 cycle.
- bus_error is sticky. err_clr clears it. If err_clr and a set occur in the same cycle, set wins.
- Strobe invariants: rd_strobe and wr_strobe are each at most one-hot, and never both nonzero in the same cycle.
- Reset mid-cycle: everything returns to reset values immediately. After release the FSM waits in IDLE for the next rise; a partial cycle emits no strobe.
- Timing at 1 MHz phi2 with SETUP_CYCLES = 8: the high phase is about 48 cycles; drive starts about 12 cycles after the pin rise.

Test Plan:
- Read slave 1: cs_mary_n = 0, rwb = 1, addr = 16'hD012, slave_sel = 4'b0010, slave1 rdata = 8'h5C. Expect one rd_strobe = 4'b0010 pulse, reg_addr = 8'h12, data_out = 8'h5C with b_en = 0 until SYNC_STAGES+1 cycles after the phi2 fall, then b_en = 1.
- Write slave 0: rwb = 0, addr = 16'hD001, data_in changes from 8'h11 to 8'h3F mid-phase, slave_sel = 4'b0001. Expect wr_strobe = 4'b0001 for one cycle after the fall, reg_wdata = 8'h3F, reg_addr = 8'h01, b_en held at 1 throughout.
- Unselected cycle: cs_mary_n = 1 for 10 consecutive phi2 periods. Expect all strobes 0, b_en = 1, bus_error = 0.
- Invalid select: slave_sel = 4'b0110 on a read. Expect data_out = 8'hAA, b_en = 0, bus_error = 1, no rd_strobe. Then err_clr pulsed in the same cycle as a new error: bus_error stays 1. err_clr alone: bus_error = 0.
- Runt and reset: phi2 high for only 4 clk_96mhz cycles gives no strobes. Asserting reset (low) while in READ with b_en = 0 forces b_en = 1 and data_out = 0 immediately; after release, the next full read cycle completes normally.
